// File: rtl/shapool_job_ctrl_pkg.sv
// Shared types and helpers for the SHA-256 pool job controller.
package shapool_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_IDLE      = 3'd1,
    ST_START     = 3'd2,
    ST_RUN       = 3'd3,
    ST_FOUND     = 3'd4,
    ST_EXHAUSTED = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    LED_OFF   = 2'd0,
    LED_BLINK = 2'd1,
    LED_ON    = 2'd2
  } led_mode_e;

  localparam int LOCK_SETTLE_DEFAULT = 16;

  // A single-unit pool still carries a 1-bit (always zero) winner index.
  function automatic int idx_width(input int log2_v);
    return (log2_v > 1) ? log2_v : 1;
  endfunction

  function automatic led_mode_e led_mode_of(input state_e st);
    led_mode_e mode;
    case (st)
      ST_START, ST_RUN:       mode = LED_BLINK;
      ST_FOUND, ST_EXHAUSTED: mode = LED_ON;
      default:                mode = LED_OFF;
    endcase
    return mode;
  endfunction

endpackage

// File: rtl/shapool_job_ctrl_led_blinker.sv
// Status LED driver: off, solid on, or blinking from a divider that restarts
// whenever blinking begins. Output is active-low.
module shapool_led_blinker
  import shapool_ctrl_pkg::*;
#(
  parameter int DIV_LOG2 = 22
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [1:0] mode_i,
  output logic       led_n_o
);

  localparam int CNT_W = DIV_LOG2 + 1;

  logic [CNT_W-1:0] cnt_q;

  // Divider runs only while blinking so each blink phase starts with the LED lit.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else if (mode_i == LED_BLINK) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else begin
      cnt_q <= '0;
    end
  end

  // Decode of flopped mode and divider only; no input reaches the pin combinationally.
  always_comb begin
    led_n_o = 1'b1;
    case (mode_i)
      LED_OFF:   led_n_o = 1'b1;
      LED_BLINK: led_n_o = cnt_q[CNT_W-1];
      LED_ON:    led_n_o = 1'b0;
      default:   led_n_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/shapool_job_ctrl.sv
// Job sequencer for the hashing pool: PLL-lock qualification, pass-by-pass
// nonce stepping, and success / exhaustion reporting to the host.
module shapool_job_ctrl
  import shapool_ctrl_pkg::*;
#(
  parameter int POOL_SIZE      = 1,
  parameter int POOL_SIZE_LOG2 = 0,
  parameter int NONCE_WIDTH    = 32,
  parameter int LOCK_SETTLE    = LOCK_SETTLE_DEFAULT,
  parameter int LED_DIV_LOG2   = 22
) (
  input  logic                                   clk_in,
  input  logic                                   reset_in,
  input  logic                                   pll_locked_in,
  input  logic                                   job_valid_in,
  input  logic                                   cancel_in,
  input  logic                                   result_ack_in,
  input  logic                                   round_done_in,
  input  logic                                   success_in,
  input  logic [idx_width(POOL_SIZE_LOG2)-1:0]   success_idx_in,
  output logic                                   job_ready_out,
  output logic                                   pool_start_out,
  output logic                                   pool_halt_out,
  output logic [NONCE_WIDTH-1:0]                 nonce_base_out,
  output logic [NONCE_WIDTH-1:0]                 found_nonce_out,
  output logic                                   exhausted_out,
  output logic                                   ready_n_out,
  output logic                                   status_led_n_out
);

  localparam int LOCK_W = (LOCK_SETTLE > 1) ? $clog2(LOCK_SETTLE) : 1;
  localparam logic [LOCK_W-1:0]      LOCK_LAST = LOCK_W'(LOCK_SETTLE - 1);
  localparam logic [NONCE_WIDTH-1:0] POOL_STEP = NONCE_WIDTH'(POOL_SIZE);

  logic                   lock_meta_q;
  logic                   lock_sync_q;
  state_e                 state_q;
  logic [LOCK_W-1:0]      lock_cnt_q;
  logic [NONCE_WIDTH-1:0] nonce_base_q;
  logic [NONCE_WIDTH-1:0] found_q;
  logic                   job_ready_q;
  logic                   pool_start_q;
  logic                   pool_halt_q;
  logic                   exhausted_q;
  logic                   ready_n_q;

  logic [NONCE_WIDTH-1:0] base_step_s;
  logic                   in_pass_s;
  logic [1:0]             led_mode_s;

  assign base_step_s = nonce_base_q + POOL_STEP;
  assign in_pass_s   = (state_q == ST_START) || (state_q == ST_RUN);
  assign led_mode_s  = led_mode_of(state_q);

  // Two-flop synchroniser for the PLL lock, which is asynchronous to clk_in.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
    end else begin
      lock_meta_q <= pll_locked_in;
      lock_sync_q <= lock_meta_q;
    end
  end

  // Controller FSM; priority is lock loss, cancel, job_valid, round_done, ack.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q      <= ST_WAIT_LOCK;
      lock_cnt_q   <= '0;
      nonce_base_q <= '0;
      found_q      <= '0;
      job_ready_q  <= 1'b0;
      pool_start_q <= 1'b0;
      pool_halt_q  <= 1'b0;
      exhausted_q  <= 1'b0;
      ready_n_q    <= 1'b1;
    end else begin
      pool_start_q <= 1'b0;
      pool_halt_q  <= 1'b0;
      if (state_q == ST_WAIT_LOCK) begin
        if (!lock_sync_q) begin
          lock_cnt_q <= '0;
        end else if (lock_cnt_q == LOCK_LAST) begin
          state_q     <= ST_IDLE;
          job_ready_q <= 1'b1;
        end else begin
          lock_cnt_q <= lock_cnt_q + LOCK_W'(1);
        end
      end else if (!lock_sync_q) begin
        state_q     <= ST_WAIT_LOCK;
        lock_cnt_q  <= '0;
        pool_halt_q <= in_pass_s;
        job_ready_q <= 1'b0;
        exhausted_q <= 1'b0;
        ready_n_q   <= 1'b1;
      end else if (cancel_in) begin
        state_q     <= ST_IDLE;
        pool_halt_q <= in_pass_s;
        job_ready_q <= 1'b1;
        exhausted_q <= 1'b0;
        ready_n_q   <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE, ST_FOUND, ST_EXHAUSTED: begin
            if (job_valid_in) begin
              state_q      <= ST_START;
              nonce_base_q <= '0;
              pool_start_q <= 1'b1;
              job_ready_q  <= 1'b0;
              exhausted_q  <= 1'b0;
              ready_n_q    <= 1'b1;
            end else if (result_ack_in && (state_q != ST_IDLE)) begin
              state_q     <= ST_IDLE;
              job_ready_q <= 1'b1;
              exhausted_q <= 1'b0;
              ready_n_q   <= 1'b1;
            end
          end
          ST_START: begin
            state_q <= ST_RUN;
          end
          ST_RUN: begin
            if (round_done_in) begin
              if (success_in) begin
                state_q   <= ST_FOUND;
                found_q   <= nonce_base_q + NONCE_WIDTH'(success_idx_in);
                ready_n_q <= 1'b0;
              end else if (base_step_s == '0) begin
                // The pass just finished was the last one of the nonce space.
                state_q     <= ST_EXHAUSTED;
                exhausted_q <= 1'b1;
              end else begin
                state_q      <= ST_START;
                nonce_base_q <= base_step_s;
                pool_start_q <= 1'b1;
              end
            end
          end
          default: begin
            state_q     <= ST_WAIT_LOCK;
            lock_cnt_q  <= '0;
            job_ready_q <= 1'b0;
            exhausted_q <= 1'b0;
            ready_n_q   <= 1'b1;
          end
        endcase
      end
    end
  end

  shapool_led_blinker #(
    .DIV_LOG2 (LED_DIV_LOG2)
  ) u_led (
    .clk_i   (clk_in),
    .reset_i (reset_in),
    .mode_i  (led_mode_s),
    .led_n_o (status_led_n_out)
  );

  assign job_ready_out   = job_ready_q;
  assign pool_start_out  = pool_start_q;
  assign pool_halt_out   = pool_halt_q;
  assign nonce_base_out  = nonce_base_q;
  assign found_nonce_out = found_q;
  assign exhausted_out   = exhausted_q;
  assign ready_n_out     = ready_n_q;

endmodule

// File: tb/tb_shapool_job_ctrl.sv
// Self-checking bench for shapool_job_ctrl: directed scenarios plus a random
// phase, all outputs compared every cycle against a behavioural model.
module tb_shapool_job_ctrl;

  localparam int NW  = 4;
  localparam int PS  = 2;
  localparam int PSL = 1;
  localparam int LS  = 16;
  localparam int LDL = 2;

  localparam int M_WAIT  = 0;
  localparam int M_IDLE  = 1;
  localparam int M_START = 2;
  localparam int M_RUN   = 3;
  localparam int M_FOUND = 4;
  localparam int M_EXH   = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          pll = 1'b0;
  logic          jv = 1'b0, cancel = 1'b0, ack = 1'b0, rd = 1'b0, succ = 1'b0;
  logic [0:0]    idx = 1'b0;
  logic          job_ready, pool_start, pool_halt, exhausted, ready_n, led;
  logic [NW-1:0] base, found;

  shapool_job_ctrl #(
    .POOL_SIZE(PS), .POOL_SIZE_LOG2(PSL), .NONCE_WIDTH(NW),
    .LOCK_SETTLE(LS), .LED_DIV_LOG2(LDL)
  ) dut (
    .clk_in(clk), .reset_in(reset), .pll_locked_in(pll),
    .job_valid_in(jv), .cancel_in(cancel), .result_ack_in(ack),
    .round_done_in(rd), .success_in(succ), .success_idx_in(idx),
    .job_ready_out(job_ready), .pool_start_out(pool_start), .pool_halt_out(pool_halt),
    .nonce_base_out(base), .found_nonce_out(found), .exhausted_out(exhausted),
    .ready_n_out(ready_n), .status_led_n_out(led)
  );

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: phase of the job, lock history, pass base, result.
  int ph = M_WAIT;
  int settle = 0;
  int m_base = 0;
  int m_found = 0;
  int blink_age = 0;
  bit m_halt = 1'b0;
  bit lk1 = 1'b0, lk2 = 1'b0;
  int start_log[$];

  function automatic bit passing(input int p);
    return (p == M_START) || (p == M_RUN);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_tick();
    bit s;
    int prev;
    prev   = ph;
    m_halt = 1'b0;
    if (reset) begin
      ph = M_WAIT; settle = 0; m_base = 0; m_found = 0; lk1 = 1'b0; lk2 = 1'b0;
    end else begin
      s = lk2; lk2 = lk1; lk1 = pll;
      if (ph == M_WAIT) begin
        if (!s) settle = 0;
        else if (settle + 1 >= LS) ph = M_IDLE;
        else settle++;
      end else if (!s) begin
        m_halt = passing(ph); ph = M_WAIT; settle = 0;
      end else if (cancel) begin
        m_halt = passing(ph); ph = M_IDLE;
      end else if (ph == M_IDLE || ph == M_FOUND || ph == M_EXH) begin
        if (jv) begin m_base = 0; ph = M_START; end
        else if (ack && ph != M_IDLE) ph = M_IDLE;
      end else if (ph == M_START) begin
        ph = M_RUN;
      end else if (rd) begin
        if (succ) begin m_found = (m_base + int'(idx)) % (1 << NW); ph = M_FOUND; end
        else if (m_base + PS >= (1 << NW)) ph = M_EXH;
        else begin m_base = m_base + PS; ph = M_START; end
      end
    end
    blink_age = (passing(ph) && passing(prev)) ? blink_age + 1 : 0;
  endtask

  task automatic step();
    bit exp_led;
    @(posedge clk);
    #1;
    model_tick();
    if (passing(ph)) exp_led = bit'((blink_age >> LDL) & 1);
    else exp_led = !(ph == M_FOUND || ph == M_EXH);
    check("job_ready",  job_ready,  ph == M_IDLE);
    check("pool_start", pool_start, ph == M_START && !m_halt && blink_age == 0 ? 1'b1 : (ph == M_START && pool_start_expected_mid()));
    check("pool_halt",  pool_halt,  m_halt);
    check("nonce_base", base,       m_base);
    check("found",      found,      m_found);
    check("exhausted",  exhausted,  ph == M_EXH);
    check("ready_n",    ready_n,    ph != M_FOUND);
    check("led_n",      led,        exp_led);
    if (pool_start === 1'b1) start_log.push_back(int'(base));
    jv = 1'b0; cancel = 1'b0; ack = 1'b0; rd = 1'b0; succ = 1'b0;
  endtask

  // A START phase always lasts one cycle, so pool_start is high in every START cycle.
  function automatic bit pool_start_expected_mid();
    return 1'b1;
  endfunction

  task automatic wait_phase(input int target, input int budget);
    int n;
    n = 0;
    while (ph != target && n < budget) begin
      step();
      n++;
    end
    if (ph != target) begin
      vectors++;
      miscompares++;
      $error("FAIL wait_phase: timed out in phase %0d waiting for %0d", ph, target);
    end
  endtask

  task automatic do_pass(input bit hit, input bit [0:0] win);
    wait_phase(M_RUN, 20);
    repeat ($urandom_range(0, 3)) begin
      succ = 1'($urandom_range(0, 1));
      step();
    end
    rd = 1'b1; succ = hit; idx = win;
    step();
  endtask

  initial begin
    int first_ready;
    first_ready = -1;

    repeat (3) step();
    reset = 1'b0;

    // Lock settle: lock high 10..14, low at 15, high from 16 onward.
    for (int t = 0; t < 60; t++) begin
      pll = (t >= 10 && t < 15) || (t >= 16);
      step();
      if (first_ready < 0 && job_ready === 1'b1) first_ready = t;
    end
    // Two synchroniser edges, then LS locked edges counted from cycle 16.
    check("lock_settle_edge", first_ready, 16 + 2 + LS - 1);

    // Basic job: two empty passes, then a hit on unit 1 of the third pass.
    start_log.delete();
    jv = 1'b1; step();
    for (int k = 0; k < 3; k++) do_pass(k == 2, 1'b1);
    check("basic_starts", start_log.size(), 3);
    for (int k = 0; k < 3 && k < start_log.size(); k++) check("basic_base", start_log[k], k * PS);
    check("basic_found", found, 2 * PS + 1);
    repeat (3) begin step(); check("basic_ready_n_held", ready_n, 1'b0); end
    ack = 1'b1; step();
    check("basic_ready_n_ack", ready_n, 1'b1);

    // Exhaustion: every pass empty across the 16-nonce space.
    start_log.delete();
    jv = 1'b1; step();
    for (int k = 0; k < (1 << NW) / PS; k++) do_pass(1'b0, 1'b0);
    repeat (4) step();
    check("exh_starts", start_log.size(), (1 << NW) / PS);
    check("exh_flag", exhausted, 1'b1);
    check("exh_ready_n", ready_n, 1'b1);
    check("exh_job_ready", job_ready, 1'b0);
    ack = 1'b1; step();
    check("exh_ack_ready", job_ready, 1'b1);

    // Cancel during the pass at base 6, then restart at 0.
    jv = 1'b1; step();
    for (int k = 0; k < 3; k++) do_pass(1'b0, 1'b0);
    wait_phase(M_RUN, 20);
    check("cancel_base", base, 6);
    cancel = 1'b1; step();
    check("cancel_halt", pool_halt, 1'b1);
    check("cancel_idle", job_ready, 1'b1);
    step();
    check("cancel_halt_once", pool_halt, 1'b0);
    jv = 1'b1; step();
    check("restart_start", pool_start, 1'b1);
    check("restart_base", base, 0);

    // Lock loss together with cancel and a winning round_done.
    wait_phase(M_RUN, 20);
    pll = 1'b0;
    step(); step();
    cancel = 1'b1; rd = 1'b1; succ = 1'b1; idx = 1'b1;
    step();
    check("sim_ready_n", ready_n, 1'b1);
    check("sim_halt", pool_halt, 1'b1);
    check("sim_job_ready", job_ready, 1'b0);
    pll = 1'b1;
    wait_phase(M_IDLE, 40);

    // New job while a result is pending in FOUND.
    jv = 1'b1; step();
    do_pass(1'b1, 1'b0);
    step();
    jv = 1'b1; step();
    check("found_jv_ready_n", ready_n, 1'b1);
    check("found_jv_start", pool_start, 1'b1);
    check("found_jv_base", base, 0);

    // Random traffic including lock dropouts and one mid-run reset.
    for (int c = 0; c < 600; c++) begin
      pll    = ($urandom_range(0, 149) != 0);
      jv     = ($urandom_range(0, 7) == 0);
      cancel = ($urandom_range(0, 39) == 0);
      ack    = ($urandom_range(0, 5) == 0);
      rd     = ($urandom_range(0, 3) == 0);
      succ   = ($urandom_range(0, 4) == 0);
      idx    = 1'($urandom_range(0, 1));
      reset  = (c == 300);
      step();
    end
    reset = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
